pe_pix_sender: RTL and testbench
================================

# pe_pix_sender

Streams one tile of pixels from the global buffer into a PE over the pbpix valid/ack interface (`ipix`/`wpix` side). It is the transmitter at the far end of the PE's pixel inputs. It generates buffer read addresses from a channel-major layout with nested column/channel/bit-plane counters. It absorbs the buffer's 1-cycle read latency and PE backpressure with a 2-entry skid FIFO. One instance drives `ipix` and one drives `wpix` of each PE.

## Interface

Parameters:
- DWD, 16, pixel word width
- AWD, 12, global-buffer address width
- CWD, 8, config field width (`PECfg::PConfDWd`)

Ports:
- i_clk  in  1  clock; one clock domain
- i_rstn  in  1  reset; asynchronous, active-low
- i_start  in  1  start pulse, sampled only in IDLE
- i_base  in  AWD  tile base address
- i_conf_chstride  in  AWD  address distance between channels
- i_conf_pch  in  CWD  channels per column
- i_conf_cols  in  CWD  columns in tile
- i_conf_xb  in  CWD  bit-planes per pixel
- o_busy  out  1  transfer in progress
- o_done  out  1  1-cycle pulse, tile complete
- o_buf_read  out  1  buffer read enable
- o_buf_raddr  out  AWD  buffer read address
- i_buf_rdata  in  DWD  read data, valid 1 cycle after o_buf_read
- o_pix  out  DWD  pixel word
- o_pix_rdy  out  1  o_pix valid
- o_pix_last  out  1  qualifies final word of tile
- i_pix_ack  in  1  PE accepts; a transfer happens when o_pix_rdy && i_pix_ack

## Operation

- States: IDLE, RUN, DRAIN.
- IDLE:
  - i_start latches base, chstride, pch, cols and xb.
  - If any count is 0: o_done pulses the next cycle, with no reads and no transfers; state stays IDLE.
  - Otherwise the state goes to RUN.
- Issue order: col outer, ch middle, b inner.
  - addr = base + ch*chstride + col*xb + b, computed modulo 2^AWD (wrap, no error).
  - Counters are CWD wide and compare to conf−1. They are held as running address accumulators, with no multipliers.
- RUN:
  - Issue a read when occupancy + inflight − pop < 2, where pop = o_pix_rdy && i_pix_ack.
  - After the last address is issued, the state goes to DRAIN.
- DRAIN: on the transfer of the word flagged last, the state goes to IDLE and o_done pulses the next cycle.
- Read data always enters the FIFO the cycle it returns. The FIFO never overflows and needs no stall path on i_buf_rdata.
- o_pix_last is tagged at issue and travels with the data through the FIFO.
- o_pix and o_pix_rdy hold stable while o_pix_rdy && !i_pix_ack.
- i_start during RUN or DRAIN is ignored. Config inputs are don't-care outside the start cycle.
- Reset mid-tile: all state clears immediately. In-flight data is discarded and no o_done is produced.

## Timing

- Reset values: o_busy=0, o_done=0, o_buf_read=0, o_buf_raddr=0, o_pix=0, o_pix_rdy=0, o_pix_last=0.
- Start sampled at edge E0:
  - o_buf_read high in cycle 1.
  - Data returns in cycle 2.
  - o_pix_rdy high in cycle 3, so first-word latency is 3 cycles.
- With i_pix_ack held high, throughput is 1 word/cycle with no bubbles.
- o_busy is high from cycle 1 through the cycle of the last transfer.
- o_done is high in the cycle after the last transfer, with o_busy=0 in that cycle. A new i_start is accepted in that same done cycle.
- Backpressure: once the FIFO holds 2 words and ack is low, o_buf_read deasserts in the same cycle. Reads resume in the cycle ack returns.

## Structure

- PECfg package gains:
  - typedef enum `SendState` {IDLE, RUN, DRAIN}.
  - struct `SendConf` {base, chstride, pch, cols, xb}.
  - localparam `SendFifoDepth = 2`.
- Sub-module `pix_skid_fifo` (2-entry, DWD+1 wide to carry the last flag, with push/pop/count). It is reusable for the psum drain path.
- Top level holds the FSM, the counters/address accumulators and the inflight flag.

## Test plan

- pch=2, cols=3, xb=2, base=0x100, chstride=0x10, ack always 1:
  - raddr sequence 0x100,0x101,0x110,0x111,0x102,0x103,0x112,0x113,0x104,0x105,0x114,0x115.
  - 12 transfers on consecutive cycles 3–14.
  - last on the 12th transfer; o_done at cycle 15.
- Same config, i_pix_ack toggling 1/0 every cycle: identical data order, never more than 2 words outstanding, o_pix stable while stalled.
- Same config, ack low for 10 cycles after start: exactly 2 reads issued, then reads resume the cycle ack rises. All 12 words are delivered.
- cols=0 start: o_done pulses at cycle 1; no o_buf_read and no o_pix_rdy ever.
- base=0xFFE, chstride=0, pch=1, cols=1, xb=4: addresses 0xFFE,0xFFF,0x000,0x001 (wrap).
- i_rstn low at cycle 6 of the first scenario: all outputs 0 asynchronously and no o_done. A fresh start then reproduces the full sequence from 0x100.

Source files
------------

// File: rtl/PECfg.sv
// rtl/PECfg.sv - PE configuration package: pixel sender state, config bundle, FIFO depth
package PECfg;
  localparam int PConfDWd      = 8;
  localparam int PGbAWd        = 12;
  localparam int SendFifoDepth = 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} SendState;

  typedef struct packed {
    logic [PGbAWd-1:0]   base;
    logic [PGbAWd-1:0]   chstride;
    logic [PConfDWd-1:0] pch;
    logic [PConfDWd-1:0] cols;
    logic [PConfDWd-1:0] xb;
  } SendConf;
endpackage

// File: rtl/pix_skid_fifo.sv
// rtl/pix_skid_fifo.sv - 2-entry skid FIFO with occupancy count; head is registered
module pix_skid_fifo
  import PECfg::*;
#(
  parameter int W = 17
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic [1:0]   o_count
);
  logic [W-1:0] r_mem [SendFifoDepth];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_count;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < SendFifoDepth; i++) r_mem[i] <= '0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ~r_wptr;
      end
      if (i_pop) r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;
endmodule

// File: rtl/pe_pix_sender.sv
// rtl/pe_pix_sender.sv - streams one channel-major tile from the global buffer into a PE pixel port
module pe_pix_sender
  import PECfg::*;
#(
  parameter int DWD = 16,
  parameter int AWD = 12,
  parameter int CWD = 8
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  input  logic           i_start,
  input  logic [AWD-1:0] i_base,
  input  logic [AWD-1:0] i_conf_chstride,
  input  logic [CWD-1:0] i_conf_pch,
  input  logic [CWD-1:0] i_conf_cols,
  input  logic [CWD-1:0] i_conf_xb,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_buf_read,
  output logic [AWD-1:0] o_buf_raddr,
  input  logic [DWD-1:0] i_buf_rdata,
  output logic [DWD-1:0] o_pix,
  output logic           o_pix_rdy,
  output logic           o_pix_last,
  input  logic           i_pix_ack
);
  localparam logic [CWD-1:0] C_ONE = CWD'(1);
  localparam logic [AWD-1:0] A_ONE = AWD'(1);

  SendState       r_state, w_state_nxt;
  SendConf        r_conf;
  logic [CWD-1:0] r_b, r_ch, r_col;
  logic [AWD-1:0] r_colbase, r_chbase, r_addr;
  logic           r_inflight, r_inflight_last, r_done;

  logic           w_pop, w_zero, w_issue, w_last_issue;
  logic           w_b_end, w_ch_end, w_col_end;
  logic [1:0]     w_count;
  logic           w_fifo_valid;
  logic [DWD:0]   w_head;
  logic [AWD-1:0] w_next_ch, w_next_col;

  assign w_pop        = o_pix_rdy & i_pix_ack;
  assign w_zero       = (i_conf_pch == '0) || (i_conf_cols == '0) || (i_conf_xb == '0);
  assign w_b_end      = (r_b   == r_conf.xb   - C_ONE);
  assign w_ch_end     = (r_ch  == r_conf.pch  - C_ONE);
  assign w_col_end    = (r_col == r_conf.cols - C_ONE);
  assign w_next_ch    = r_chbase + r_conf.chstride;
  assign w_next_col   = r_colbase + AWD'(r_conf.xb);
  // Occupancy plus the in-flight word, net of this cycle's pop, must leave room for one more.
  assign w_issue      = (r_state == RUN) &&
                        (({1'b0, w_count} + {2'b0, r_inflight} - {2'b0, w_pop}) < 3'd2);
  assign w_last_issue = w_issue && w_b_end && w_ch_end && w_col_end;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_start && !w_zero) w_state_nxt = RUN;
      RUN:     if (w_last_issue) w_state_nxt = DRAIN;
      DRAIN:   if (w_pop && o_pix_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_conf          <= '0;
      r_b             <= '0;
      r_ch            <= '0;
      r_col           <= '0;
      r_colbase       <= '0;
      r_chbase        <= '0;
      r_addr          <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_last_issue;
      r_done          <= ((r_state == IDLE) && i_start && w_zero) ||
                         ((r_state == DRAIN) && w_pop && o_pix_last);
      if ((r_state == IDLE) && i_start) begin
        r_conf    <= '{base: i_base, chstride: i_conf_chstride, pch: i_conf_pch,
                       cols: i_conf_cols, xb: i_conf_xb};
        r_b       <= '0;
        r_ch      <= '0;
        r_col     <= '0;
        r_colbase <= i_base;
        r_chbase  <= i_base;
        r_addr    <= i_base;
      end else if (w_issue) begin
        if (!w_b_end) begin
          r_b    <= r_b + C_ONE;
          r_addr <= r_addr + A_ONE;
        end else if (!w_ch_end) begin
          r_b      <= '0;
          r_ch     <= r_ch + C_ONE;
          r_chbase <= w_next_ch;
          r_addr   <= w_next_ch;
        end else begin
          r_b       <= '0;
          r_ch      <= '0;
          r_col     <= r_col + C_ONE;
          r_colbase <= w_next_col;
          r_chbase  <= w_next_col;
          r_addr    <= w_next_col;
        end
      end
    end
  end

  pix_skid_fifo #(.W(DWD + 1)) u_fifo (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_push  (r_inflight),
    .i_data  ({r_inflight_last, i_buf_rdata}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_valid (w_fifo_valid),
    .o_count (w_count)
  );

  assign o_busy      = (r_state != IDLE);
  assign o_done      = r_done;
  assign o_buf_read  = w_issue;
  assign o_buf_raddr = r_addr;
  assign o_pix       = w_head[DWD-1:0];
  assign o_pix_rdy   = w_fifo_valid;
  assign o_pix_last  = w_fifo_valid & w_head[DWD];
endmodule

// File: tb/tb_pe_pix_sender.sv
// tb/tb_pe_pix_sender.sv - self-checking bench for pe_pix_sender against a loop-nest tile model
module tb_pe_pix_sender;
  localparam int DWD = 16;
  localparam int AWD = 12;
  localparam int CWD = 8;

  logic           clk = 1'b0;
  logic           i_rstn, i_start, i_pix_ack;
  logic [AWD-1:0] i_base, i_conf_chstride;
  logic [CWD-1:0] i_conf_pch, i_conf_cols, i_conf_xb;
  logic           o_busy, o_done, o_buf_read, o_pix_rdy, o_pix_last;
  logic [AWD-1:0] o_buf_raddr;
  logic [DWD-1:0] i_buf_rdata, o_pix;
  logic [DWD-1:0] mem [0:4095];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pe_pix_sender #(.DWD(DWD), .AWD(AWD), .CWD(CWD)) dut (
    .i_clk(clk), .i_rstn(i_rstn), .i_start(i_start), .i_base(i_base),
    .i_conf_chstride(i_conf_chstride), .i_conf_pch(i_conf_pch),
    .i_conf_cols(i_conf_cols), .i_conf_xb(i_conf_xb), .o_busy(o_busy),
    .o_done(o_done), .o_buf_read(o_buf_read), .o_buf_raddr(o_buf_raddr),
    .i_buf_rdata(i_buf_rdata), .o_pix(o_pix), .o_pix_rdy(o_pix_rdy),
    .o_pix_last(o_pix_last), .i_pix_ack(i_pix_ack)
  );

  always @(posedge clk) if (o_buf_read) i_buf_rdata <= mem[o_buf_raddr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode: 0 ack always high, 1 ack on odd cycles, 2 ack low through cycle 10, 3 random ack
  task automatic run_tile(input logic [11:0] base, input logic [11:0] stride,
                          input logic [7:0] pch, input logic [7:0] cols, input logic [7:0] xb,
                          input int mode, input int rst_at);
    int unsigned exp_addr[$];
    logic [11:0] got_addr[$];
    int n, max_cyc, reads, xfers, first_cyc, last_cyc, done_cyc, done_cnt, max_out, rdy_seen;
    int reads_at10;
    logic read_at11, prev_stall, exp_busy;
    logic [15:0] prev_pix;
    reads = 0; xfers = 0; first_cyc = 0; last_cyc = 0; done_cyc = 0; done_cnt = 0;
    max_out = 0; rdy_seen = 0; reads_at10 = 0; read_at11 = 1'b0; prev_stall = 1'b0; prev_pix = '0;
    for (int c = 0; c < int'(cols); c++)
      for (int ch = 0; ch < int'(pch); ch++)
        for (int b = 0; b < int'(xb); b++)
          exp_addr.push_back((int'(base) + ch * int'(stride) + c * int'(xb) + b) & 32'hFFF);
    n = exp_addr.size();
    max_cyc = 8 * n + 40;
    i_base = base; i_conf_chstride = stride; i_conf_pch = pch; i_conf_cols = cols;
    i_conf_xb = xb; i_start = 1'b1; i_pix_ack = 1'b0;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      @(posedge clk); #1;
      i_start = 1'b0;
      case (mode)
        0:       i_pix_ack = 1'b1;
        1:       i_pix_ack = (cyc % 2) == 1;
        2:       i_pix_ack = cyc > 10;
        default: i_pix_ack = $urandom_range(0, 3) != 0;
      endcase
      #1;
      if (cyc == rst_at) begin
        i_rstn = 1'b0; #1;
        chk("rst_busy", o_busy, 0);       chk("rst_done", o_done, 0);
        chk("rst_read", o_buf_read, 0);   chk("rst_raddr", o_buf_raddr, 0);
        chk("rst_pix", o_pix, 0);         chk("rst_rdy", o_pix_rdy, 0);
        chk("rst_last", o_pix_last, 0);
        repeat (2) @(posedge clk);
        #1 i_rstn = 1'b1;
        repeat (4) begin
          @(posedge clk); #1;
          chk("post_rst_done", o_done, 0);
          chk("post_rst_busy", o_busy, 0);
        end
        return;
      end
      exp_busy = (xfers < n);
      if (!o_done) chk("busy", o_busy, exp_busy);
      if (prev_stall) begin
        chk("stall_rdy", o_pix_rdy, 1);
        chk("stall_pix", o_pix, prev_pix);
      end
      if (o_buf_read) begin got_addr.push_back(o_buf_raddr); reads++; end
      if (o_pix_rdy) rdy_seen++;
      if (o_pix_rdy && i_pix_ack) begin
        if (xfers < n) begin
          chk("pix", o_pix, mem[exp_addr[xfers]]);
          chk("last", o_pix_last, xfers == n - 1);
        end else chk("extra_xfer", xfers, n);
        if (xfers == 0) first_cyc = cyc;
        last_cyc = cyc;
        xfers++;
      end
      prev_stall = o_pix_rdy && !i_pix_ack;
      prev_pix = o_pix;
      if (reads - xfers > max_out) max_out = reads - xfers;
      if (cyc == 10) reads_at10 = reads;
      if (cyc == 11) read_at11 = o_buf_read;
      if (o_done) begin
        done_cnt++;
        if (done_cnt == 1) done_cyc = cyc;
        chk("done_busy", o_busy, 0);
      end
      if (done_cnt > 0 && cyc >= done_cyc + ((n == 0) ? 3 : 0)) break;
    end
    chk("done_count", done_cnt, 1);
    chk("xfers", xfers, n);
    chk("reads", reads, n);
    for (int i = 0; i < n && i < got_addr.size(); i++) chk("raddr", got_addr[i], exp_addr[i]);
    chk("outstanding_le2", max_out <= 2, 1);
    if (n > 0) begin
      chk("done_cycle", done_cyc, last_cyc + 1);
      if (mode == 0) begin
        chk("first_xfer_cycle", first_cyc, 3);
        chk("done_cycle_abs", done_cyc, n + 3);
      end
      if (mode == 2) begin
        chk("reads_while_stalled", reads_at10, 2);
        chk("read_resumes", read_at11, 1);
      end
    end else begin
      chk("zero_done_cycle", done_cyc, 1);
      chk("zero_rdy_seen", rdy_seen, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = DWD'($urandom);
    i_rstn = 1'b0; i_start = 1'b0; i_pix_ack = 1'b0; i_base = '0; i_conf_chstride = '0;
    i_conf_pch = '0; i_conf_cols = '0; i_conf_xb = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", o_busy, 0);     chk("reset_done", o_done, 0);
    chk("reset_read", o_buf_read, 0); chk("reset_raddr", o_buf_raddr, 0);
    chk("reset_pix", o_pix, 0);       chk("reset_rdy", o_pix_rdy, 0);
    chk("reset_last", o_pix_last, 0);
    i_rstn = 1'b1;
    @(posedge clk); #1;
    run_tile(12'h100, 12'h010, 8'd2, 8'd3, 8'd2, 0, 0);
    run_tile(12'h100, 12'h010, 8'd2, 8'd3, 8'd2, 1, 0);
    run_tile(12'h100, 12'h010, 8'd2, 8'd3, 8'd2, 2, 0);
    run_tile(12'h100, 12'h010, 8'd2, 8'd0, 8'd2, 0, 0);
    run_tile(12'hFFE, 12'h000, 8'd1, 8'd1, 8'd4, 0, 0);
    run_tile(12'h100, 12'h010, 8'd2, 8'd3, 8'd2, 0, 6);
    run_tile(12'h100, 12'h010, 8'd2, 8'd3, 8'd2, 0, 0);
    for (int t = 0; t < 6; t++)
      run_tile(12'($urandom), 12'($urandom), 8'($urandom_range(1, 3)),
               8'($urandom_range(0, 3)), 8'($urandom_range(1, 4)), 3, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
